// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encodings for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REFILL = 2'd1,
        ST_DRAIN  = 2'd2
    } fetch_state_e;

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [DATA_WIDTH-1:0] next_pc(input logic [DATA_WIDTH-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_icache_array.sv
// Direct-mapped i-cache storage: valid bits, tags and data words.
// One combinational read port (lookup) and one write port shared by
// line invalidation, word fill and valid/tag install.
module icache_array
    import fetch_unit_pkg::*;
#(
    parameter int INDEX_W  = 6,
    parameter int OFFSET_W = 2,
    parameter int TAG_W    = DATA_WIDTH - 2 - OFFSET_W - INDEX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_index,
    input  logic [OFFSET_W-1:0]   rd_word,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [OFFSET_W-1:0]   wr_word,
    input  logic                  wr_data_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_set_valid,
    input  logic                  wr_clr_valid,
    input  logic [TAG_W-1:0]      wr_tag
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      valid_d;
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [WORDS];

    // Valid-bit update: invalidation wins over install on the same line.
    always_comb begin
        valid_d = valid_q;
        if (wr_clr_valid) begin
            valid_d[wr_index] = FALSE;
        end else if (wr_set_valid) begin
            valid_d[wr_index] = TRUE;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only storage that must come up cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= {LINES{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; a line is unusable until valid.
    always_ff @(posedge clk) begin
        if (wr_set_valid) begin
            tag_mem[wr_index] <= wr_tag;
        end
        if (wr_data_en) begin
            data_mem[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a direct-mapped i-cache.
// Looks up the fetch PC each cycle, hands hits to the decoder and refills
// missing lines one word at a time from memory (one request in flight).
// Optional build macro: ICACHE_PERF_EN adds hit/miss counter ports.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          INDEX_W  = 6,
    parameter int          OFFSET_W = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_jump_ena,
    input  logic [31:0] in_jump_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_decoder_ena,
    input  logic        in_decoder_ready,
    output logic        out_mem_ena,
    input  logic        in_mem_ready,
    input  logic [31:0] in_mem_inst,
`ifdef ICACHE_PERF_EN
    output logic [31:0] out_hit_cnt,
    output logic [31:0] out_miss_cnt,
`endif
    output logic [31:0] out_address
);

    localparam int TAG_W  = DATA_WIDTH - 2 - OFFSET_W - INDEX_W;
    localparam int LINE_W = DATA_WIDTH - 2 - OFFSET_W;

    fetch_state_e          state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [OFFSET_W-1:0]   k_q, k_d;
    logic                  pend_q, pend_d;
    logic [31:0]           out_inst_q, out_inst_d;
    logic [31:0]           out_pc_q, out_pc_d;
    logic                  out_decoder_ena_q, out_decoder_ena_d;
    logic                  out_mem_ena_q, out_mem_ena_d;
    logic [31:0]           out_address_q, out_address_d;

    logic [TAG_W-1:0]      pc_tag_s;
    logic [INDEX_W-1:0]    pc_index_s;
    logic [OFFSET_W-1:0]   pc_word_s;
    logic                  rd_valid_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  hit_s;
    logic                  slot_free_s;
    logic                  lookup_s;
    logic                  last_word_s;
    logic [INDEX_W-1:0]    wr_index_s;
    logic                  wr_data_en_s;
    logic                  wr_set_valid_s;
    logic                  wr_clr_valid_s;

    assign pc_tag_s    = pc_q[31 -: TAG_W];
    assign pc_index_s  = pc_q[2+OFFSET_W +: INDEX_W];
    assign pc_word_s   = pc_q[2 +: OFFSET_W];
    assign hit_s       = rd_valid_s && (rd_tag_s == pc_tag_s);
    assign slot_free_s = !out_decoder_ena_q || in_decoder_ready;
    assign lookup_s    = (state_q == ST_RUN) && !in_jump_ena && ena && slot_free_s;
    assign last_word_s = (k_q == {OFFSET_W{1'b1}});

    icache_array #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (pc_index_s),
        .rd_word      (pc_word_s),
        .rd_valid     (rd_valid_s),
        .rd_tag       (rd_tag_s),
        .rd_data      (rd_data_s),
        .wr_index     (wr_index_s),
        .wr_word      (k_q),
        .wr_data_en   (wr_data_en_s),
        .wr_data      (in_mem_inst),
        .wr_set_valid (wr_set_valid_s),
        .wr_clr_valid (wr_clr_valid_s),
        .wr_tag       (line_q[LINE_W-1 -: TAG_W])
    );

    // Next-state, fetch output and refill request logic; jump has top priority.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        line_d            = line_q;
        k_d               = k_q;
        pend_d            = pend_q;
        out_inst_d        = out_inst_q;
        out_pc_d          = out_pc_q;
        out_decoder_ena_d = out_decoder_ena_q && !in_decoder_ready;
        out_mem_ena_d     = FALSE;
        out_address_d     = out_address_q;
        wr_index_s        = line_q[INDEX_W-1:0];
        wr_data_en_s      = FALSE;
        wr_set_valid_s    = FALSE;
        wr_clr_valid_s    = FALSE;

        if (in_jump_ena) begin
            pc_d              = in_jump_pc;
            out_decoder_ena_d = FALSE;
            case (state_q)
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_REFILL, ST_DRAIN: begin
                    // A response still to come must be swallowed before new requests.
                    if (pend_q && !in_mem_ready) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                        pend_d  = FALSE;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    pend_d  = FALSE;
                end
            endcase
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lookup_s) begin
                        if (hit_s) begin
                            out_inst_d        = rd_data_s;
                            out_pc_d          = pc_q;
                            out_decoder_ena_d = TRUE;
                            pc_d              = next_pc(pc_q);
                        end else begin
                            // Line is invalidated up front so an aborted fill never hits.
                            state_d        = ST_REFILL;
                            line_d         = pc_q[31:2+OFFSET_W];
                            k_d            = {OFFSET_W{1'b0}};
                            wr_index_s     = pc_index_s;
                            wr_clr_valid_s = TRUE;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_REFILL: begin
                    if (pend_q) begin
                        // Responses are written even while ena is low.
                        if (in_mem_ready) begin
                            wr_data_en_s = TRUE;
                            pend_d       = FALSE;
                            if (last_word_s) begin
                                wr_set_valid_s = TRUE;
                                state_d        = ST_RUN;
                            end else begin
                                k_d = k_q + OFFSET_W'(1'b1);
                            end
                        end else begin
                            pend_d = TRUE;
                        end
                    end else if (ena) begin
                        out_mem_ena_d = TRUE;
                        out_address_d = {line_q, k_q, 2'b00};
                        pend_d        = TRUE;
                    end else begin
                        pend_d = FALSE;
                    end
                end
                ST_DRAIN: begin
                    if (in_mem_ready) begin
                        pend_d  = FALSE;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    pend_d  = FALSE;
                end
            endcase
        end
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= ST_RUN;
            pc_q              <= RESET_PC;
            line_q            <= {LINE_W{1'b0}};
            k_q               <= {OFFSET_W{1'b0}};
            pend_q            <= 1'b0;
            out_inst_q        <= 32'h0;
            out_pc_q          <= 32'h0;
            out_decoder_ena_q <= 1'b0;
            out_mem_ena_q     <= 1'b0;
            out_address_q     <= 32'h0;
        end else begin
            state_q           <= state_d;
            pc_q              <= pc_d;
            line_q            <= line_d;
            k_q               <= k_d;
            pend_q            <= pend_d;
            out_inst_q        <= out_inst_d;
            out_pc_q          <= out_pc_d;
            out_decoder_ena_q <= out_decoder_ena_d;
            out_mem_ena_q     <= out_mem_ena_d;
            out_address_q     <= out_address_d;
        end
    end

    assign out_inst        = out_inst_q;
    assign out_pc          = out_pc_q;
    assign out_decoder_ena = out_decoder_ena_q;
    assign out_mem_ena     = out_mem_ena_q;
    assign out_address     = out_address_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Count accepted hit lookups and refill entries; both wrap at 2^32.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (lookup_s && hit_s) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (lookup_s) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign out_hit_cnt  = hit_cnt_q;
    assign out_miss_cnt = miss_cnt_q;
`endif

endmodule
